// File: rtl/native_to_axi4_master_if.sv
// rtl/native_to_axi4_master_if.sv - AXI4 channel bundle with master/slave views for the native bridge
interface axi4_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4
);
    logic                      axi_aclk;
    logic [ID_WIDTH-1:0]       awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ID_WIDTH-1:0]       arid;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [ID_WIDTH-1:0]       rid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output axi_aclk,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  axi_aclk,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/native_to_axi4_master.sv
// rtl/native_to_axi4_master.sv - native app port to AXI4 master bridge with contiguous-command burst coalescing
// Optional response error reporting (resp_err, err_cnt) is enabled by defining N2A_RESP_ERR_EN.
module native_to_axi4_master #(
    parameter int ADDR_WIDTH    = 27,
    parameter int DATA_WIDTH    = 256,
    parameter int ADDR_STEP     = 8,
    parameter int MAX_LEN       = 64,
    parameter int WFIFO_DEPTH   = 128,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int AXI_ID        = 0,
    parameter int ID_WIDTH      = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    axi4_if.master                  axi_inf,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
`ifdef N2A_RESP_ERR_EN
    output logic                    resp_err,
    output logic [15:0]             err_cnt,
`endif
    output logic                    init_calib_complete
);
    localparam int CW  = $clog2(MAX_LEN + 1);
    localparam int TW  = $clog2(FLUSH_TIMEOUT + 1);
    localparam int PW  = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int FCW = $clog2(WFIFO_DEPTH + 1);
    localparam int MW  = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_COL_WR, S_AW, S_W, S_B, S_COL_RD, S_AR, S_R
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d, wbeat_q, wbeat_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  calib_q, calib_d;
    logic                  awvalid_q, awvalid_d, arvalid_q, arvalid_d;
    logic                  bready_q, bready_d, rready_q, rready_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;

    logic [DATA_WIDTH-1:0] wdata_mem [WFIFO_DEPTH];
    logic [MW-1:0]         wmask_mem [WFIFO_DEPTH];

    logic cmd_wr, cmd_rd, cmd_ok, in_col, same_dir, contig, breaks;
    logic accept, cmd_take, fifo_push, fifo_pop, w_last, flush;

    assign cmd_wr   = (app_cmd == 3'b000);
    assign cmd_rd   = (app_cmd == 3'b001);
    assign cmd_ok   = cmd_wr || cmd_rd;
    assign in_col   = (state_q == S_COL_WR) || (state_q == S_COL_RD);
    assign same_dir = ((state_q == S_COL_WR) && cmd_wr) || ((state_q == S_COL_RD) && cmd_rd);
    assign contig   = (app_addr == last_q + ADDR_WIDTH'(ADDR_STEP));
    // A command that cannot extend the current burst is refused so it is retaken from IDLE after the flush.
    assign breaks   = in_col && app_en && cmd_ok && !(same_dir && contig);
    assign app_rdy  = calib_q && ((state_q == S_IDLE) ||
                                  (in_col && (cnt_q != CW'(MAX_LEN)) && !breaks));
    assign accept   = app_en && app_rdy;
    assign cmd_take = accept && cmd_ok;

    assign w_last         = (wbeat_q == cnt_q - CW'(1));
    assign axi_inf.wvalid = (state_q == S_W) && (fcnt_q != '0);
    assign fifo_pop       = axi_inf.wvalid && axi_inf.wready;
    assign app_wdf_rdy    = calib_q && ((fcnt_q != FCW'(WFIFO_DEPTH)) || fifo_pop);
    assign fifo_push      = app_wdf_wren && app_wdf_rdy;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        wbeat_d    = wbeat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        flush      = 1'b0;
        calib_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (cmd_take) begin
                    base_d  = app_addr;
                    last_d  = app_addr;
                    cnt_d   = CW'(1);
                    timer_d = '0;
                    state_d = cmd_wr ? S_COL_WR : S_COL_RD;
                end
            end
            S_COL_WR, S_COL_RD: begin
                if ((cnt_q == CW'(MAX_LEN)) || breaks) begin
                    flush = 1'b1;
                end else if (cmd_take) begin
                    cnt_d   = cnt_q + CW'(1);
                    last_d  = app_addr;
                    timer_d = '0;
                end else if (timer_q == TW'(FLUSH_TIMEOUT - 1)) begin
                    flush = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (flush) begin
                    wbeat_d = '0;
                    state_d = (state_q == S_COL_WR) ? S_AW : S_AR;
                end
            end
            S_AW: if (axi_inf.awready) state_d = S_W;
            S_W: begin
                if (fifo_pop) begin
                    if (w_last) state_d = S_B;
                    else        wbeat_d = wbeat_q + CW'(1);
                end
            end
            S_B:  if (axi_inf.bvalid && bready_q) state_d = S_IDLE;
            S_AR: if (axi_inf.arready) state_d = S_R;
            S_R: begin
                if (axi_inf.rvalid && rready_q) begin
                    rd_data_d  = axi_inf.rdata;
                    rd_valid_d = 1'b1;
                    if (axi_inf.rlast) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        awvalid_d = (state_d == S_AW);
        arvalid_d = (state_d == S_AR);
        bready_d  = (state_d == S_B);
        rready_d  = (state_d == S_R);
        wr_ptr_d  = fifo_push ? ((wr_ptr_q == PW'(WFIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = fifo_pop  ? ((rd_ptr_q == PW'(WFIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        fcnt_d    = fcnt_q + FCW'(fifo_push) - FCW'(fifo_pop);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            wbeat_q    <= '0;
            calib_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            wbeat_q    <= wbeat_d;
            calib_q    <= calib_d;
            awvalid_q  <= awvalid_d;
            arvalid_q  <= arvalid_d;
            bready_q   <= bready_d;
            rready_q   <= rready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_push) begin
            wdata_mem[wr_ptr_q] <= app_wdf_data;
            wmask_mem[wr_ptr_q] <= app_wdf_mask;
        end
    end

    assign axi_inf.axi_aclk = clock;
    assign axi_inf.awid     = ID_WIDTH'(AXI_ID);
    assign axi_inf.awaddr   = base_q;
    assign axi_inf.awlen    = 8'(cnt_q - CW'(1));
    assign axi_inf.awsize   = 3'($clog2(DATA_WIDTH / 8));
    assign axi_inf.awburst  = 2'b01;
    assign axi_inf.awvalid  = awvalid_q;
    assign axi_inf.wdata    = wdata_mem[rd_ptr_q];
    assign axi_inf.wstrb    = ~wmask_mem[rd_ptr_q];
    assign axi_inf.wlast    = w_last;
    assign axi_inf.bready   = bready_q;
    assign axi_inf.arid     = ID_WIDTH'(AXI_ID);
    assign axi_inf.araddr   = base_q;
    assign axi_inf.arlen    = 8'(cnt_q - CW'(1));
    assign axi_inf.arsize   = 3'($clog2(DATA_WIDTH / 8));
    assign axi_inf.arburst  = 2'b01;
    assign axi_inf.arvalid  = arvalid_q;
    assign axi_inf.rready   = rready_q;

    assign app_rd_data         = rd_data_q;
    assign app_rd_data_valid   = rd_valid_q;
    assign app_rd_data_end     = rd_valid_q;
    assign init_calib_complete = calib_q;

`ifdef N2A_RESP_ERR_EN
    logic        resp_err_q, err_beat;
    logic [15:0] err_cnt_q;
    assign err_beat = (axi_inf.bvalid && bready_q && (axi_inf.bresp != 2'b00)) ||
                      (axi_inf.rvalid && rready_q && (axi_inf.rresp != 2'b00));
    always_ff @(posedge clock) begin
        if (rst) begin
            resp_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (err_beat) begin
            resp_err_q <= 1'b1;
            err_cnt_q  <= err_cnt_q + {15'd0, (err_cnt_q != 16'hFFFF)};
        end
    end
    assign resp_err = resp_err_q;
    assign err_cnt  = err_cnt_q;
    logic unused_in;
    assign unused_in = ^{app_wdf_end, axi_inf.bid, axi_inf.rid};
`else
    logic unused_in;
    assign unused_in = ^{app_wdf_end, axi_inf.bid, axi_inf.rid, axi_inf.bresp, axi_inf.rresp};
`endif
endmodule

// File: tb/tb_native_to_axi4_master.sv
// tb/tb_native_to_axi4_master.sv - directed bench for native_to_axi4_master with a small AXI slave model
module tb_native_to_axi4_master;
    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic [26:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [255:0] app_wdf_data = '0;
    logic [31:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
`ifdef N2A_RESP_ERR_EN
    logic         resp_err;
    logic [15:0]  err_cnt;
`endif

    axi4_if #(.ADDR_WIDTH(27), .DATA_WIDTH(256), .ID_WIDTH(4)) axi ();

    native_to_axi4_master dut (
        .clock(clock), .rst(rst), .axi_inf(axi),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
`ifdef N2A_RESP_ERR_EN
        .resp_err(resp_err), .err_cnt(err_cnt),
`endif
        .init_calib_complete(init_calib_complete)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int b_cnt = 0;
    int b_pend = 0;
    int r_beat = 0;
    int rd_seen = 0;
    int aw_cyc = 0;
    int push_waits = 0;
    logic [34:0]  aw_log[$];
    logic [34:0]  ar_log[$];
    logic [34:0]  ar_pend[$];
    logic [288:0] w_log[$];
    logic [287:0] exp_w[$];
    logic [255:0] exp_rd[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mkdata(input int s);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(s) * 32'h9E3779B1 + 32'(k);
        return r;
    endfunction

    function automatic logic [31:0] mkmask(input int s);
        return (32'(s) * 32'h01234567) ^ 32'hF0F0_0F0F;
    endfunction

    function automatic logic [255:0] rd_pat(input logic [26:0] a, input int beat);
        return {8{32'hA500_0000 | 32'(a)}} ^ 256'(beat);
    endfunction

    // AXI slave model: always-ready address/data channels, B and R answered from recorded handshakes.
    initial begin
        axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rid = '0; axi.rlast = 1'b0; axi.rdata = '0;
        forever begin
            @(negedge clock);
            if (rst) begin
                ar_pend.delete();
                b_pend = 0;
                r_beat = 0;
            end else begin
                if (app_rd_data_valid) begin
                    rd_seen++;
                    if (exp_rd.size() == 0) check_val("rd_unexpected", 1, 0);
                    else check_val("rd_data", {app_rd_data_end, app_rd_data}, {1'b1, exp_rd.pop_front()});
                end
                if (axi.awvalid && axi.awready) begin
                    aw_log.push_back({axi.awaddr, axi.awlen});
                    aw_cyc = cyc;
                    check_val("aw_attr", {axi.awid, axi.awsize, axi.awburst}, {4'd0, 3'd5, 2'd1});
                end
                if (axi.wvalid && axi.wready) begin
                    w_log.push_back({axi.wlast, axi.wstrb, axi.wdata});
                    if (axi.wlast) b_pend++;
                end
                if (axi.bvalid && axi.bready) begin
                    b_cnt++;
                    b_pend--;
                end
                if (axi.arvalid && axi.arready) begin
                    ar_log.push_back({axi.araddr, axi.arlen});
                    ar_pend.push_back({axi.araddr, axi.arlen});
                    check_val("ar_attr", {axi.arid, axi.arsize, axi.arburst}, {4'd0, 3'd5, 2'd1});
                end
                if (axi.rvalid && axi.rready) begin
                    exp_rd.push_back(axi.rdata);
                    if (axi.rlast) begin
                        void'(ar_pend.pop_front());
                        r_beat = 0;
                    end else r_beat++;
                end
            end
            @(posedge clock);
            #1;
            axi.bvalid = (b_pend > 0);
            if (ar_pend.size() > 0) begin
                axi.rvalid = 1'b1;
                axi.rdata  = rd_pat(ar_pend[0][34:8], r_beat);
                axi.rlast  = (r_beat == int'(ar_pend[0][7:0]));
            end else begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int s);
        logic ok = 1'b0;
        app_wdf_wren = 1'b1;
        app_wdf_data = mkdata(s);
        app_wdf_mask = mkmask(s);
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            ok = app_wdf_rdy;
            step();
            if (ok) break;
            push_waits++;
        end
        app_wdf_wren = 1'b0;
        if (ok) exp_w.push_back({~mkmask(s), mkdata(s)});
        else check_val("wdf_timeout", 0, 1);
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [26:0] a);
        logic ok = 1'b0;
        app_en = 1'b1;
        app_cmd = c;
        app_addr = a;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            ok = app_rdy;
            step();
            if (ok) break;
        end
        app_en = 1'b0;
        if (!ok) check_val("cmd_timeout", 0, 1);
    endtask

    task automatic wait_b(input int target);
        for (int n = 0; n < 2000 && b_cnt < target; n++) step();
        if (b_cnt < target) check_val("b_timeout", 32'(b_cnt), 32'(target));
    endtask

    task automatic verify_w(input int n, input int first_len);
        if (w_log.size() < n || exp_w.size() < n) begin
            check_val("w_count", 32'(w_log.size()), 32'(n));
        end else begin
            for (int i = 0; i < n; i++) begin
                logic last = (i == first_len - 1) || (i == n - 1);
                check_val("w_beat", {31'd0, w_log.pop_front()}, {31'd0, last, exp_w.pop_front()});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {app_rdy, app_wdf_rdy, app_rd_data_valid, axi.awvalid, axi.arvalid,
                        axi.wvalid, axi.bready, axi.rready, init_calib_complete}, 9'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0;
        repeat (3) step();
        @(negedge clock);
        check_reset_outputs("reset_outputs");
        step();
        rst = 1'b0;
        step();
        @(negedge clock);
        check_val("calib_after_reset", {init_calib_complete, app_rdy, app_wdf_rdy}, 3'b111);
        step();

        // 1: four contiguous writes coalesce into one burst
        for (int i = 0; i < 4; i++) push(10 + i);
        for (int i = 0; i < 4; i++) send_cmd(3'b000, 27'h100 + 27'(i * 8));
        wait_b(1);
        check_val("t1_aw_count", 32'(aw_log.size()), 32'd1);
        if (aw_log.size() > 0) check_val("t1_aw", aw_log.pop_front(), {27'h100, 8'd3});
        verify_w(4, 4);
        @(negedge clock);
        check_val("t1_idle_rdy", app_rdy, 1'b1);
        step();

        // 2: 70 contiguous writes split at MAX_LEN
        for (int i = 0; i < 70; i++) push(100 + i);
        for (int i = 0; i < 70; i++) send_cmd(3'b000, 27'(i * 8));
        wait_b(3);
        check_val("t2_aw_count", 32'(aw_log.size()), 32'd2);
        if (aw_log.size() > 1) begin
            check_val("t2_aw0", aw_log.pop_front(), {27'h0, 8'd63});
            check_val("t2_aw1", aw_log.pop_front(), {27'h200, 8'd5});
        end
        verify_w(70, 64);

        // 3: non-contiguous reads become two single-beat bursts
        rd_seen = 0;
        send_cmd(3'b001, 27'h40);
        send_cmd(3'b001, 27'h80);
        for (int n = 0; n < 500 && rd_seen < 2; n++) step();
        check_val("t3_rd_pulses", 32'(rd_seen), 32'd2);
        check_val("t3_ar_count", 32'(ar_log.size()), 32'd2);
        if (ar_log.size() > 1) begin
            check_val("t3_ar0", ar_log.pop_front(), {27'h40, 8'd0});
            check_val("t3_ar1", ar_log.pop_front(), {27'h80, 8'd0});
        end

        // 4: lone write flushes on the idle timeout
        push(200);
        send_cmd(3'b000, 27'h8);
        c0 = cyc;
        wait_b(4);
        check_val("t4_aw_latency", 32'(aw_cyc - c0), 32'd16);
        if (aw_log.size() > 0) check_val("t4_aw", aw_log.pop_front(), {27'h8, 8'd0});
        verify_w(1, 1);

        // 5: data ahead of commands, masks inverted into strobes
        push_waits = 0;
        for (int i = 0; i < 8; i++) push(300 + i * 17);
        check_val("t5_wdf_rdy_waits", 32'(push_waits), 32'd0);
        for (int i = 0; i < 8; i++) send_cmd(3'b000, 27'h1000 + 27'(i * 8));
        wait_b(5);
        if (aw_log.size() > 0) check_val("t5_aw", aw_log.pop_front(), {27'h1000, 8'd7});
        verify_w(8, 8);

        // 6: reset during the second W beat, then a clean write
        for (int i = 0; i < 4; i++) push(400 + i);
        for (int i = 0; i < 4; i++) send_cmd(3'b000, 27'h2000 + 27'(i * 8));
        w_log.delete();
        for (int n = 0; n < 200 && w_log.size() < 1; n++) step();
        check_val("t6_beat1_seen", 32'(w_log.size()), 32'd1);
        rst = 1'b1;
        step();
        @(negedge clock);
        check_reset_outputs("t6_reset_outputs");
        step();
        rst = 1'b0;
        w_log.delete();
        exp_w.delete();
        aw_log.delete();
        b_cnt = 0;
        step();
        send_cmd(3'b000, 27'h3000);
        push(500);
        wait_b(1);
        if (aw_log.size() > 0) check_val("t6_aw", aw_log.pop_front(), {27'h3000, 8'd0});
        else check_val("t6_aw_count", 32'(aw_log.size()), 32'd1);
        verify_w(1, 1);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
